// File: rtl/sreg_tx_ctrl.sv
// -----------------------------------------------------------------------------
// sreg_tx_ctrl
//
// Transmit-side controller. It takes one parallel word from a producer through
// a val/rdy handshake and loads it into an internal shift register. It then
// shifts the word out MSB-first, one bit per accepted beat, under an output
// val/rdy handshake. After the last beat it waits a programmable inter-frame
// gap before it accepts another word.
//
// Parameters:
//   NBITS      - data word width and frame length in bits (>= 2)
//   GAP_CYCLES - idle cycles after a frame's last beat before in_rdy returns
//
// Ports:
//   i_clk      - clock, rising edge
//   i_rst_n    - asynchronous active-low reset
//   i_in_val   - producer presents a valid word
//   o_in_rdy   - controller accepts a word this cycle
//   i_in_msg   - parallel word to transmit
//   o_out_val  - o_out_bit is valid
//   i_out_rdy  - consumer accepts o_out_bit this cycle
//   o_out_bit  - current serial bit
//   o_out_sof  - high with the first bit of a frame
//   o_out_last - high with the last bit of a frame
//   o_busy     - high in any state other than IDLE
//
// Optional feature (macro SREG_TX_CTRL_PARITY_EN):
//   When defined, every frame carries one extra even-parity beat after the
//   data bits, and o_out_last moves to that parity beat.
// -----------------------------------------------------------------------------
module sreg_tx_ctrl #(
  parameter int NBITS      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_val,
  output logic             o_in_rdy,
  input  logic [NBITS-1:0] i_in_msg,
  output logic             o_out_val,
  input  logic             i_out_rdy,
  output logic             o_out_bit,
  output logic             o_out_sof,
  output logic             o_out_last,
  output logic             o_busy
);

  localparam int CNT_W = $clog2(NBITS + 1);
`ifdef SREG_TX_CTRL_PARITY_EN
  localparam int LAST_IDX = NBITS;
`else
  localparam int LAST_IDX = NBITS - 1;
`endif
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LAST_IDX);

  // The gap counter is kept at least one bit wide so GAP_CYCLES=0 still builds.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           r_state;
  logic [NBITS-1:0] r_shiftReg;
  logic [CNT_W-1:0] r_bitCnt;
  logic [GAP_W-1:0] r_gapCnt;
`ifdef SREG_TX_CTRL_PARITY_EN
  logic             r_parity;
`endif

  logic [NBITS-1:0] w_nextReg;
  logic [CNT_W-1:0] w_nextCnt;
  logic             w_lastBeat;
  logic             w_nextBit;

  assign w_nextReg  = {r_shiftReg[NBITS-2:0], 1'b0};
  assign w_nextCnt  = r_bitCnt + 1'b1;
  assign w_lastBeat = (r_bitCnt == LAST_BEAT);

  // The bit presented on the next beat: the new MSB, or the parity flop
  // once every data bit has gone out.
`ifdef SREG_TX_CTRL_PARITY_EN
  assign w_nextBit = (w_nextCnt == CNT_W'(NBITS)) ? r_parity : w_nextReg[NBITS-1];
`else
  assign w_nextBit = w_nextReg[NBITS-1];
`endif

  // All outputs are registered. They are loaded with the values that belong
  // to the state being entered, so they change on the same edge as the state.
  // o_in_rdy comes up one edge after reset release. That keeps it low for the
  // whole time reset is held. Only a word offered while o_in_rdy is high is
  // accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_shiftReg <= '0;
      r_bitCnt   <= '0;
      r_gapCnt   <= '0;
`ifdef SREG_TX_CTRL_PARITY_EN
      r_parity   <= 1'b0;
`endif
      o_in_rdy   <= 1'b0;
      o_out_val  <= 1'b0;
      o_out_bit  <= 1'b0;
      o_out_sof  <= 1'b0;
      o_out_last <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (o_in_rdy && i_in_val) begin
            r_state    <= SHIFT;
            r_shiftReg <= i_in_msg;
            r_bitCnt   <= '0;
`ifdef SREG_TX_CTRL_PARITY_EN
            r_parity   <= ^i_in_msg;
`endif
            o_in_rdy   <= 1'b0;
            o_out_val  <= 1'b1;
            o_out_bit  <= i_in_msg[NBITS-1];
            o_out_sof  <= 1'b1;
            o_out_last <= 1'b0;
            o_busy     <= 1'b1;
          end else begin
            o_in_rdy <= 1'b1;
            o_busy   <= 1'b0;
          end
        end

        SHIFT: begin
          if (i_out_rdy) begin
            if (w_lastBeat) begin
              // The counter returns to 0 rather than incrementing, so it
              // never wraps inside its width.
              r_shiftReg <= '0;
              r_bitCnt   <= '0;
              r_gapCnt   <= '0;
              o_out_val  <= 1'b0;
              o_out_bit  <= 1'b0;
              o_out_sof  <= 1'b0;
              o_out_last <= 1'b0;
              if (GAP_CYCLES > 0) begin
                r_state <= GAP;
              end else begin
                r_state  <= IDLE;
                o_in_rdy <= 1'b1;
                o_busy   <= 1'b0;
              end
            end else begin
              r_shiftReg <= w_nextReg;
              r_bitCnt   <= w_nextCnt;
              o_out_bit  <= w_nextBit;
              o_out_sof  <= 1'b0;
              o_out_last <= (w_nextCnt == LAST_BEAT);
            end
          end
        end

        GAP: begin
          if (r_gapCnt == GAP_LAST) begin
            r_state  <= IDLE;
            o_in_rdy <= 1'b1;
            o_busy   <= 1'b0;
          end else begin
            r_gapCnt <= r_gapCnt + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sreg_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sreg_tx_ctrl
//
// Self-checking bench for sreg_tx_ctrl with NBITS=8 and GAP_CYCLES=1.
// Expected serial bits come from the word with shift arithmetic. When
// SREG_TX_CTRL_PARITY_EN is defined, an extra bit is appended that holds the
// even parity of the word (its popcount modulo 2).
// -----------------------------------------------------------------------------
module tb_sreg_tx_ctrl;

  localparam int NBITS      = 8;
  localparam int GAP_CYCLES = 1;
`ifdef SREG_TX_CTRL_PARITY_EN
  localparam int FRAME_LEN = NBITS + 1;
`else
  localparam int FRAME_LEN = NBITS;
`endif

  logic             clk = 1'b0;
  logic             rstN;
  logic             inVal;
  logic             inRdy;
  logic [NBITS-1:0] inMsg;
  logic             outVal;
  logic             outRdy;
  logic             outBit;
  logic             outSof;
  logic             outLast;
  logic             busy;

  int checks = 0;
  int errors = 0;

  sreg_tx_ctrl #(
    .NBITS      (NBITS),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_in_val   (inVal),
    .o_in_rdy   (inRdy),
    .i_in_msg   (inMsg),
    .o_out_val  (outVal),
    .i_out_rdy  (outRdy),
    .o_out_bit  (outBit),
    .o_out_sof  (outSof),
    .o_out_last (outLast),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  // Keeps a broken design from hanging the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: beat idx of the frame for a given word.
  function automatic logic expBit(input logic [NBITS-1:0] word, input int idx);
    if (idx < NBITS) return ((word >> (NBITS - 1 - idx)) & 1) != 0;
    return ($countones(word) % 2) == 1;
  endfunction

  task automatic waitReady();
    int n = 0;
    while (inRdy !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("inRdyWait", 32'(inRdy), 32'd1);
  endtask

  // Sends one word, checks every shift cycle and the gap that follows.
  // Beats stallA/stallB are held off for stallLen cycles. randomRdy throttles
  // out_rdy at random. keepVal leaves in_val high with a zero word during the
  // frame, and that word must not be taken.
  task automatic applyStimulus(input logic [NBITS-1:0] word, input bit randomRdy,
                               input bit keepVal, input int stallA, input int stallB,
                               input int stallLen, output int shiftCycles);
    int beat = 0;
    int stalled = 0;
    bit rdy;
    waitReady();
    inVal = 1'b1;
    inMsg = word;
    tick();
    if (keepVal) begin
      inMsg = '0;
    end else begin
      inVal = 1'b0;
      inMsg = NBITS'($urandom);
    end
    shiftCycles = 0;
    while (beat < FRAME_LEN && shiftCycles < 200) begin
      checkOutput("outVal", 32'(outVal), 32'd1);
      checkOutput($sformatf("bit%0d", beat), 32'(outBit), 32'(expBit(word, beat)));
      checkOutput($sformatf("sof%0d", beat), 32'(outSof), 32'(beat == 0));
      checkOutput($sformatf("last%0d", beat), 32'(outLast), 32'(beat == FRAME_LEN - 1));
      checkOutput("inRdyShift", 32'(inRdy), 32'd0);
      checkOutput("busyShift", 32'(busy), 32'd1);
      if ((beat == stallA || beat == stallB) && stalled < stallLen) begin
        rdy = 1'b0;
        stalled++;
      end else if (randomRdy) begin
        rdy = ($urandom_range(0, 2) != 0);
      end else begin
        rdy = 1'b1;
      end
      outRdy = rdy;
      tick();
      shiftCycles++;
      if (rdy) begin
        beat++;
        stalled = 0;
      end
    end
    checkOutput("frameDone", 32'(beat), 32'(FRAME_LEN));
    for (int g = 0; g < GAP_CYCLES; g++) begin
      outRdy = 1'($urandom);
      checkOutput("gapOutVal", 32'(outVal), 32'd0);
      checkOutput("gapInRdy", 32'(inRdy), 32'd0);
      checkOutput("gapBusy", 32'(busy), 32'd1);
      checkOutput("gapLast", 32'(outLast), 32'd0);
      tick();
    end
    checkOutput("postGapInRdy", 32'(inRdy), 32'd1);
    checkOutput("postGapBusy", 32'(busy), 32'd0);
    checkOutput("postGapOutVal", 32'(outVal), 32'd0);
    outRdy = 1'b0;
  endtask

  initial begin
    int cyc;
    rstN   = 1'b1;
    inVal  = 1'b0;
    inMsg  = '0;
    outRdy = 1'b0;

    // Reset is asserted asynchronously, before any clock edge.
    #3 rstN = 1'b0;
    #1;
    checkOutput("rstInRdy", 32'(inRdy), 32'd0);
    checkOutput("rstOutVal", 32'(outVal), 32'd0);
    checkOutput("rstOutBit", 32'(outBit), 32'd0);
    checkOutput("rstSof", 32'(outSof), 32'd0);
    checkOutput("rstLast", 32'(outLast), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #3 rstN = 1'b1;
    tick();
    checkOutput("idleInRdy", 32'(inRdy), 32'd1);
    checkOutput("idleBusy", 32'(busy), 32'd0);
    checkOutput("idleOutVal", 32'(outVal), 32'd0);

    // Single frame with out_rdy held high.
    $display("[TB] single frame 8'hD6");
    applyStimulus(8'b1101_0110, 1'b0, 1'b0, -1, -1, 0, cyc);
    checkOutput("singleCycles", 32'(cyc), 32'(FRAME_LEN));

    // Back-pressure on beats 2 and 5.
    $display("[TB] back-pressure 8'hC9");
    applyStimulus(8'hC9, 1'b0, 1'b0, 2, 5, 2, cyc);
    checkOutput("bpCycles", 32'(cyc), 32'(FRAME_LEN + 4));

    // in_val stays high with 8'h00 during the 8'hFF frame.
    $display("[TB] busy rejection");
    applyStimulus(8'hFF, 1'b0, 1'b1, -1, -1, 0, cyc);
    applyStimulus(8'h00, 1'b0, 1'b0, -1, -1, 0, cyc);

    // Reset while beat 4 is on the wire.
    $display("[TB] reset mid-frame");
    waitReady();
    inVal = 1'b1;
    inMsg = 8'hFF;
    tick();
    inVal  = 1'b0;
    outRdy = 1'b1;
    repeat (4) tick();
    checkOutput("preAbortVal", 32'(outVal), 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("abortOutVal", 32'(outVal), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortInRdy", 32'(inRdy), 32'd0);
    repeat (3) begin
      tick();
      checkOutput("abortLast", 32'(outLast), 32'd0);
      checkOutput("abortHoldVal", 32'(outVal), 32'd0);
    end
    #2 rstN = 1'b1;
    outRdy = 1'b0;
    tick();
    checkOutput("abortIdleInRdy", 32'(inRdy), 32'd1);
    applyStimulus(8'h01, 1'b0, 1'b0, -1, -1, 0, cyc);

`ifdef SREG_TX_CTRL_PARITY_EN
    $display("[TB] parity frames");
    applyStimulus(8'b1101_0110, 1'b0, 1'b0, -1, -1, 0, cyc);
    applyStimulus(8'h03, 1'b0, 1'b0, -1, -1, 0, cyc);
`endif

    // Random words with random consumer throttling.
    $display("[TB] random frames");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(NBITS'($urandom), 1'b1, 1'b0, -1, -1, 0, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sreg_tx_ctrl.md
Name: sreg_tx_ctrl

Overview:
- Transmit-side controller that sequences an internal NBITS-wide universal shift register to serialize words MSB-first.
- Accepts one parallel word through a val/rdy handshake and parallel-loads it into the register.
- Shifts the word out one bit per accepted beat under an output val/rdy handshake, then enforces a programmable inter-frame gap.
- Sits between a word-oriented producer and a bit-serial link.

Parameters:
- NBITS, 8, data word width and frame length in bits (NBITS >= 2).
- GAP_CYCLES, 1, idle cycles after a frame's last beat before in_rdy reasserts (0 allowed).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous active-low reset; 0 resets all state immediately, independent of clk.
- in_val  input  1  producer presents a valid word.
- in_rdy  output  1  controller accepts a word this cycle.
- in_msg  input  NBITS  parallel word to transmit.
- out_val  output  1  out_bit is valid.
- out_rdy  input  1  consumer accepts out_bit this cycle.
- out_bit  output  1  current serial bit.
- out_sof  output  1  high with the first bit of a frame.
- out_last  output  1  high with the last bit of a frame.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0): state=IDLE, shift register=0, bit counter=0, gap counter=0.
  - in_rdy=0, out_val=0, out_bit=0, out_sof=0, out_last=0, busy=0, all held while reset is asserted.
  - After reset deasserts: state is IDLE with in_rdy=1.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_rdy=1, out_val=0.
  - If in_val is high, the word is accepted: the register parallel-loads in_msg, counter=0, next state=SHIFT.
- SHIFT:
  - in_rdy=0, out_val=1, out_bit=reg[NBITS-1].
  - out_sof=1 when counter=0; out_last=1 when counter=NBITS-1.
  - When out_val and out_rdy are both high, the beat is accepted: reg shifts left with 0 inserted at the LSB, and counter increments.
  - If out_rdy=0, reg, counter and all outputs hold.
  - When the last beat is accepted: next state=GAP if GAP_CYCLES>0, else IDLE.
- GAP:
  - in_rdy=0, out_val=0.
  - Counts GAP_CYCLES cycles, then moves to IDLE.
- Latency:
  - A word accepted at edge N drives its first bit starting the cycle after edge N.
  - With continuous out_rdy, a frame occupies NBITS cycles.
  - Minimum word-to-word spacing is NBITS+GAP_CYCLES+1 cycles.
- No pipelining: in_rdy is never high while a frame is in flight. Words presented then are not accepted and must be held by the producer.
- in_msg is sampled only on the accepting edge; later changes do not affect the frame.
- out_rdy is ignored outside SHIFT.
- Counter width is clog2(NBITS+1); it never wraps inside a frame.
- Reset mid-frame: the frame is aborted with no partial completion, and no out_last is ever produced for it.
- in_val and out_rdy are independent of one another; no simultaneous-event priority is needed because their states are disjoint.

Optional Feature:
- Macro: SREG_TX_CTRL_PARITY_EN.
- Defined:
  - Each frame carries one extra beat after the NBITS data bits: an even-parity bit equal to the XOR of the accepted word.
  - out_last is asserted on the parity beat, not on data bit NBITS-1.
  - The frame is NBITS+1 beats; the counter covers 0..NBITS.
  - Parity is computed at load and held in a dedicated flop, which resets to 0.
- Undefined: frames are exactly NBITS beats and no parity logic exists.

Test Plan:
- Reset then IDLE with NBITS=8, GAP_CYCLES=1: drive reset=0 asynchronously mid-cycle, release, in_val=0 -> all outputs 0 during reset; in_rdy=1, busy=0 afterwards.
- Single frame, in_msg=8'b1101_0110, out_rdy=1 continuously:
  - out_bit sequence = 1,1,0,1,0,1,1,0 on consecutive cycles.
  - out_sof high on beat 0 only; out_last high on beat 7 only.
  - One GAP cycle with in_rdy=0, then in_rdy=1.
- Back-pressure, in_msg=8'hC9, out_rdy low on beats 2 and 5 for 2 cycles each:
  - bit held stable while stalled.
  - Sequence still 1,1,0,0,1,0,0,1; frame takes 12 cycles.
- Busy rejection: in_val held high with in_msg=8'hFF, then 8'h00 offered during SHIFT:
  - 8'h00 is not accepted.
  - Next frame starts only after the GAP cycle; 8'hFF transmitted as eight 1s.
- Reset mid-frame: load 8'hFF, assert reset after beat 3 ->
  - out_val=0 and no out_last is produced.
  - After release, a new word 8'h01 transmits as 0,0,0,0,0,0,0,1.
- Parity (SREG_TX_CTRL_PARITY_EN defined):
  - in_msg=8'b1101_0110 -> 9 beats, beat 8 = 1, with out_last on beat 8.
  - in_msg=8'h03 -> beat 8 = 0.
